voice_bank_generator: RTL and testbench

//  Source side of the sample mixer: 16 sawtooth tone voices keyed by keys[15:0].

---
 rtl/voice_bank_generator.sv | 72 +++++++
 tb/tb_voice_bank_generator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/voice_bank_generator.sv
// voice_bank_generator: 16 keyed sawtooth voices with click-free release, feeding the wave-averaging mixer
module voice_bank_generator #(
  parameter logic [7:0] BASE_DIV = 8'd96,
  parameter logic [7:0] STEP_DIV = 8'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] keys,
  input  logic        sample_tick,
  output logic [15:0] playing,
  output logic [95:0] wave_bus,
  output logic        sample_valid
);
  typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;
  logic [15:0] k1_q, ks_q;
  logic sv_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      k1_q <= '0;
      ks_q <= '0;
      sv_q <= 1'b0;
    end else begin
      k1_q <= keys;
      ks_q <= k1_q;
      sv_q <= sample_tick;
    end
  assign sample_valid = sv_q;
  for (genvar v = 0; v < 16; v++) begin : g_voice
    localparam logic [7:0] RELOAD = BASE_DIV - STEP_DIV * 8'(v) - 8'd1;
    state_t st_q;
    logic [5:0] ph_q;
    logic [7:0] dc_q;
    logic pl_q, wrap;
    assign wrap = dc_q == 8'd0;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        st_q <= IDLE;
        ph_q <= '0;
        dc_q <= '0;
        pl_q <= 1'b0;
      end else case (st_q)
        IDLE: if (ks_q[v]) begin
          st_q <= PLAY;
          dc_q <= RELOAD;
          pl_q <= 1'b1;
        end
        PLAY: begin
          if (sample_tick) begin
            dc_q <= wrap ? RELOAD : dc_q - 8'd1;
            ph_q <= ph_q + {5'd0, wrap};
          end
          if (!ks_q[v]) st_q <= RELEASE;
        end
        default: begin
          if (sample_tick) begin
            dc_q <= wrap ? RELOAD : dc_q - 8'd1;
            ph_q <= ph_q + {5'd0, wrap};
          end
          // a wrapped sawtooth ends the note silently; re-press resumes without reload
          if (ks_q[v]) st_q <= PLAY;
          else if (ph_q == 6'd0) begin
            st_q <= IDLE;
            dc_q <= '0;
            ph_q <= '0;
            pl_q <= 1'b0;
          end
        end
      endcase
    assign playing[v] = pl_q;
    assign wave_bus[6*v +: 6] = pl_q ? ph_q : 6'd0;
  end
endmodule

// File: tb/tb_voice_bank_generator.sv
// tb_voice_bank_generator: scoreboard bench for the sawtooth voice bank
module tb_voice_bank_generator;
  localparam int BASE = 4, STEP = 1;
  logic clk = 1'b0, reset = 1'b1, sample_tick = 1'b0, sample_valid;
  logic [15:0] keys = '0, playing;
  logic [95:0] wave_bus;
  int errors = 0, checks = 0;
  int m_st[16], m_ph[16], m_dc[16];
  logic [15:0] m_k1, m_ks;
  logic m_valid;
  logic [111:0] sbq[$];
  always #5 clk = ~clk;
  voice_bank_generator #(.BASE_DIV(8'(BASE)), .STEP_DIV(8'(STEP))) dut (
    .clk(clk), .reset(reset), .keys(keys), .sample_tick(sample_tick),
    .playing(playing), .wave_bus(wave_bus), .sample_valid(sample_valid)
  );
  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [111:0] model_out();
    logic [15:0] p;
    logic [95:0] w;
    p = '0;
    w = '0;
    for (int v = 0; v < 16; v++) if (m_st[v] != 0) begin
      p[v] = 1'b1;
      w[6*v +: 6] = 6'(m_ph[v]);
    end
    return {p, w};
  endfunction
  task automatic model_reset();
    for (int v = 0; v < 16; v++) begin
      m_st[v] = 0;
      m_ph[v] = 0;
      m_dc[v] = 0;
    end
    m_k1 = '0;
    m_ks = '0;
    m_valid = 1'b0;
  endtask
  task automatic model_edge();
    for (int v = 0; v < 16; v++) begin
      int rl, np, nd;
      rl = (BASE - v * STEP - 1) & 255;
      np = m_ph[v];
      nd = m_dc[v];
      if (sample_tick) begin
        if (m_dc[v] == 0) begin
          nd = rl;
          np = (m_ph[v] + 1) % 64;
        end else nd = m_dc[v] - 1;
      end
      case (m_st[v])
        0: if (m_ks[v]) begin
          m_st[v] = 1;
          m_dc[v] = rl;
        end
        1: begin
          m_ph[v] = np;
          m_dc[v] = nd;
          if (!m_ks[v]) m_st[v] = 2;
        end
        default: if (m_ks[v]) begin
          m_st[v] = 1;
          m_ph[v] = np;
          m_dc[v] = nd;
        end else if (m_ph[v] == 0) begin
          m_st[v] = 0;
          m_dc[v] = 0;
        end else begin
          m_ph[v] = np;
          m_dc[v] = nd;
        end
      endcase
    end
    m_ks = m_k1;
    m_k1 = keys;
    m_valid = sample_tick;
    if (sample_tick) sbq.push_back(model_out());
  endtask
  task automatic step();
    logic [111:0] e;
    @(posedge clk);
    if (reset) model_reset(); else model_edge();
    @(negedge clk);
    check("valid", 96'(sample_valid), 96'(m_valid));
    if (sample_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got output with no expected entry");
      end else begin
        e = sbq.pop_front();
        check("playing", 96'(playing), 96'(e[111:96]));
        check("wave", wave_bus, e[95:0]);
      end
    end
  endtask
  initial begin
    bit found;
    int n;
    logic [5:0] last, prev;
    model_reset();
    #1;
    check("rst_playing", 96'(playing), 96'd0);
    check("rst_wave", wave_bus, 96'd0);
    check("rst_valid", 96'(sample_valid), 96'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample_tick = (i % 3) != 0;
      step();
      check("idle_playing", 96'(playing), 96'd0);
      check("idle_wave", wave_bus, 96'd0);
    end
    sample_tick = 1'b1;
    keys[0] = 1'b1;
    step(); check("lat1", 96'(playing[0]), 96'd0);
    step(); check("lat2", 96'(playing[0]), 96'd0);
    step(); check("lat3", 96'(playing[0]), 96'd1);
    check("lat3_phase", 96'(wave_bus[5:0]), 96'd0);
    found = 1'b0;
    prev = wave_bus[5:0];
    for (n = 0; n < 400 && !found; n++) begin
      step();
      if (prev == 6'd63 && wave_bus[5:0] == 6'd0 && playing[0]) found = 1'b1;
      prev = wave_bus[5:0];
    end
    check("wrap_held", 96'(found), 96'd1);
    found = 1'b0;
    for (n = 0; n < 200 && !found; n++) begin
      step();
      found = wave_bus[5:0] == 6'd30;
    end
    check("reach30", 96'(found), 96'd1);
    keys[0] = 1'b0;
    found = 1'b0;
    for (n = 0; n < 400 && !found; n++) begin
      sample_tick = $urandom_range(0, 3) != 0;
      step();
      check("rel_hold", 96'(playing[0]), 96'd1);
      found = wave_bus[5:0] == 6'd40;
    end
    check("reach40", 96'(found), 96'd1);
    keys[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample_tick = $urandom_range(0, 3) != 0;
      step();
      check("repress_hold", 96'(playing[0]), 96'd1);
    end
    sample_tick = 1'b1;
    found = 1'b0;
    for (n = 0; n < 400 && !found; n++) begin
      step();
      found = wave_bus[5:0] == 6'd5;
    end
    check("reach5", 96'(found), 96'd1);
    keys[0] = 1'b0;
    found = 1'b0;
    last = wave_bus[5:0];
    for (n = 0; n < 400 && !found; n++) begin
      step();
      if (!playing[0]) found = 1'b1;
      else last = wave_bus[5:0];
    end
    check("rel_done", 96'(found), 96'd1);
    check("rel_last_phase", 96'(last), 96'd0);
    check("rel_slot0", 96'(wave_bus[5:0]), 96'd0);
    keys = 16'h0008;
    repeat (3) step();
    prev = wave_bus[23:18];
    for (int i = 0; i < 12; i++) begin
      step();
      check("v3_playing", 96'(playing), 96'h0008);
      check("v3_inc", 96'(wave_bus[23:18]), 96'(6'(prev + 6'd1)));
      check("v3_others", wave_bus & ~(96'h3f << 18), 96'd0);
      prev = wave_bus[23:18];
    end
    keys = 16'hFFFF;
    repeat (10) step();
    reset = 1'b1;
    #1;
    check("async_playing", 96'(playing), 96'd0);
    check("async_wave", wave_bus, 96'd0);
    model_reset();
    step();
    reset = 1'b0;
    step(); check("rs_lat1", 96'(playing), 96'd0);
    step(); check("rs_lat2", 96'(playing), 96'd0);
    step(); check("rs_lat3", 96'(playing), 96'hFFFF);
    check("rs_phase0", wave_bus, 96'd0);
    repeat (8) step();
    check("sb_drain", 96'(sbq.size()), 96'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
